// File: rtl/tl_pkg.sv
// Shared TileLink UH constants, responder state encoding and beat helper.
package tl_pkg;

   localparam logic [2:0] TL_PUTFULL    = 3'd0;
   localparam logic [2:0] TL_PUTPARTIAL = 3'd1;
   localparam logic [2:0] TL_GET        = 3'd4;
   localparam logic [2:0] TL_ACK        = 3'd0;
   localparam logic [2:0] TL_ACKDATA    = 3'd1;

   localparam int TL_MAX_SIZE = 7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_ACK
   } state_t;

   // Oversized requests collapse to one beat so the error reply stays short.
   function automatic logic [5:0] tl_beats(input logic [3:0] size);
      if (size <= 4'd2 || size > 4'(TL_MAX_SIZE)) begin
         return 6'd1;
      end
      return 6'd1 << (size - 4'd2);
   endfunction

endpackage

// File: rtl/tlmem_ram.sv
// 32-bit synchronous SRAM, read-enable-gated output register.
// TLMEM_PUT_EN adds a byte-masked write port; otherwise it is a ROM.
module tlmem_ram #(
   parameter int WORDS = 4096,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
`ifdef TLMEM_PUT_EN
   ,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [3:0]    wmask,
   input  logic [31:0]   wdata
`endif
);

   logic [31:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

`ifdef TLMEM_PUT_EN
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask[b]) begin
               mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end
`endif

endmodule

// File: rtl/tlmem_responder.sv
// TileLink UH memory responder: Get bursts, single-word Put, denied replies.
// Define TLMEM_PUT_EN for a writable RAM; otherwise every Put is denied.
module tlmem_responder
   import tl_pkg::*;
#(
   parameter int          WORDS = 4096,
   parameter logic [31:0] BASE  = 32'h0000_0000
) (
   input  logic        core_clock_i,
   input  logic        core_reset_ni,
   input  logic [2:0]  tl_a_opcode,
   input  logic [2:0]  tl_a_param,
   input  logic [3:0]  tl_a_size,
   input  logic [31:0] tl_a_address,
   input  logic [3:0]  tl_a_mask,
   input  logic [31:0] tl_a_data,
   input  logic        tl_a_corrupt,
   input  logic        tl_a_valid,
   output logic        tl_a_ready,
   output logic [2:0]  tl_d_opcode,
   output logic [1:0]  tl_d_param,
   output logic [3:0]  tl_d_size,
   output logic        tl_d_denied,
   output logic        tl_d_corrupt,
   output logic [31:0] tl_d_data,
   output logic        tl_d_valid,
   input  logic        tl_d_ready
);

   localparam int          AW   = $clog2(WORDS);
   localparam logic [32:0] SPAN = 33'(WORDS) << 2;

   state_t        state;
   logic [AW-1:0] word;
   logic [5:0]    rd_left;
   logic [5:0]    beat_left;
   logic [5:0]    drain_left;
   logic          err_q;
   logic          data_sel;
   logic [31:0]   rdata;
   logic [32:0]   off;
   logic [5:0]    req_n;
   logic          is_get;
   logic          is_put;
   logic          req_err;
   logic          put_deny;
   logic          a_take;
   logic          rd_fire;

   assign tl_a_ready = (state == S_IDLE || state == S_DRAIN)
                       && core_reset_ni;
   assign tl_d_param = 2'b00;
   assign tl_d_data  = data_sel ? rdata : 32'h0;
   assign a_take     = state == S_IDLE && tl_a_valid;
   // Next word is fetched only when the D slot is free or being drained.
   assign rd_fire    = state == S_READ && rd_left != 6'd0
                       && (!tl_d_valid || tl_d_ready);

   always_comb begin
      off    = {1'b0, tl_a_address} - {1'b0, BASE};
      is_get = tl_a_opcode == TL_GET;
      is_put = tl_a_opcode == TL_PUTFULL
               || tl_a_opcode == TL_PUTPARTIAL;
      req_n  = tl_beats(tl_a_size);
      req_err = (!is_get && !is_put)
         || tl_a_size > 4'(TL_MAX_SIZE)
         || (tl_a_address & ((32'd1 << tl_a_size) - 32'd1)) != 32'd0
         || tl_a_address < BASE
         || off + (33'd1 << tl_a_size) > SPAN;
`ifndef TLMEM_PUT_EN
      req_err = req_err || is_put;
`endif
      put_deny = req_err || req_n != 6'd1;
   end

`ifdef TLMEM_PUT_EN
   logic          wr_pend;
   logic [AW-1:0] wr_addr;
   logic [3:0]    wr_mask;
   logic [31:0]   wr_data;

   always_ff @(posedge core_clock_i) begin
      if (!core_reset_ni) begin
         wr_pend <= 1'b0;
      end else begin
         wr_pend <= a_take && is_put && !put_deny;
      end
      if (a_take) begin
         wr_addr <= off[AW+1:2];
         wr_mask <= tl_a_mask;
         wr_data <= tl_a_data;
      end
   end
`endif

   tlmem_ram #(
      .WORDS (WORDS)
   ) u_ram (
      .clk   (core_clock_i),
      .re    (rd_fire && !err_q),
      .raddr (word),
      .rdata (rdata)
`ifdef TLMEM_PUT_EN
      ,
      .we    (wr_pend && core_reset_ni),
      .waddr (wr_addr),
      .wmask (wr_mask),
      .wdata (wr_data)
`endif
   );

   logic unused_ok;
`ifdef TLMEM_PUT_EN
   assign unused_ok = ^{tl_a_param, tl_a_corrupt,
                        off[32:AW+2], off[1:0]};
`else
   assign unused_ok = ^{tl_a_param, tl_a_corrupt,
                        off[32:AW+2], off[1:0],
                        tl_a_mask, tl_a_data};
`endif

   always_ff @(posedge core_clock_i) begin
      if (!core_reset_ni) begin
         state        <= S_IDLE;
         tl_d_valid   <= 1'b0;
         tl_d_opcode  <= 3'd0;
         tl_d_size    <= 4'd0;
         tl_d_denied  <= 1'b0;
         tl_d_corrupt <= 1'b0;
         data_sel     <= 1'b0;
         rd_left      <= 6'd0;
         beat_left    <= 6'd0;
         drain_left   <= 6'd0;
         err_q        <= 1'b0;
         word         <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (tl_a_valid) begin
                  tl_d_size <= tl_a_size;
                  if (is_get) begin
                     state     <= S_READ;
                     word      <= off[AW+1:2];
                     rd_left   <= req_n;
                     beat_left <= req_n;
                     err_q     <= req_err;
                  end else begin
                     tl_d_opcode  <= TL_ACK;
                     tl_d_denied  <= put_deny;
                     tl_d_corrupt <= 1'b0;
                     data_sel     <= 1'b0;
                     if (is_put && req_n != 6'd1) begin
                        state      <= S_DRAIN;
                        drain_left <= req_n - 6'd1;
                     end else begin
                        state      <= S_ACK;
                        tl_d_valid <= 1'b1;
                     end
                  end
               end
            end
            S_READ: begin
               if (rd_fire) begin
                  tl_d_valid   <= 1'b1;
                  tl_d_opcode  <= TL_ACKDATA;
                  tl_d_denied  <= err_q;
                  tl_d_corrupt <= err_q;
                  data_sel     <= !err_q;
                  word         <= word + 1'b1;
                  rd_left      <= rd_left - 6'd1;
               end else if (tl_d_ready) begin
                  tl_d_valid <= 1'b0;
               end
               if (tl_d_valid && tl_d_ready) begin
                  beat_left <= beat_left - 6'd1;
                  if (beat_left == 6'd1) begin
                     state <= S_IDLE;
                  end
               end
            end
            S_DRAIN: begin
               if (tl_a_valid) begin
                  drain_left <= drain_left - 6'd1;
                  if (drain_left == 6'd1) begin
                     state      <= S_ACK;
                     tl_d_valid <= 1'b1;
                  end
               end
            end
            S_ACK: begin
               if (tl_d_ready) begin
                  tl_d_valid <= 1'b0;
                  state      <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tlmem_responder.sv
// Directed vector bench for tlmem_responder (backdoor-preloaded memory).
module tb_tlmem_responder;
   import tl_pkg::*;

`ifdef TLMEM_PUT_EN
   localparam bit PUT = 1'b1;
`else
   localparam bit PUT = 1'b0;
`endif

   logic        core_clock_i = 1'b0;
   logic        core_reset_ni = 1'b0;
   logic [2:0]  tl_a_opcode = 3'd0;
   logic [2:0]  tl_a_param = 3'd0;
   logic [3:0]  tl_a_size = 4'd0;
   logic [31:0] tl_a_address = 32'd0;
   logic [3:0]  tl_a_mask = 4'd0;
   logic [31:0] tl_a_data = 32'd0;
   logic        tl_a_corrupt = 1'b0;
   logic        tl_a_valid = 1'b0;
   logic        tl_a_ready;
   logic [2:0]  tl_d_opcode;
   logic [1:0]  tl_d_param;
   logic [3:0]  tl_d_size;
   logic        tl_d_denied;
   logic        tl_d_corrupt;
   logic [31:0] tl_d_data;
   logic        tl_d_valid;
   logic        tl_d_ready = 1'b1;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [31:0] model [4096];

   tlmem_responder dut (
      .core_clock_i  (core_clock_i),
      .core_reset_ni (core_reset_ni),
      .tl_a_opcode   (tl_a_opcode),
      .tl_a_param    (tl_a_param),
      .tl_a_size     (tl_a_size),
      .tl_a_address  (tl_a_address),
      .tl_a_mask     (tl_a_mask),
      .tl_a_data     (tl_a_data),
      .tl_a_corrupt  (tl_a_corrupt),
      .tl_a_valid    (tl_a_valid),
      .tl_a_ready    (tl_a_ready),
      .tl_d_opcode   (tl_d_opcode),
      .tl_d_param    (tl_d_param),
      .tl_d_size     (tl_d_size),
      .tl_d_denied   (tl_d_denied),
      .tl_d_corrupt  (tl_d_corrupt),
      .tl_d_data     (tl_d_data),
      .tl_d_valid    (tl_d_valid),
      .tl_d_ready    (tl_d_ready)
   );

   always #5 core_clock_i = ~core_clock_i;
   always @(posedge core_clock_i) cyc <= cyc + 1;

   typedef struct {
      logic [2:0]  op;
      logic [3:0]  sz;
      logic [31:0] addr;
      int          n_a;
      int          n_d;
      logic [2:0]  d_op;
      logic        den;
      logic        cor;
      bit          use_data;
      int          word;
      int          lat;
   } vec_t;

   localparam int NV = 14;
   vec_t vec [NV];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge core_clock_i);
      #1;
   endtask

   task automatic a_send(input logic [2:0] op, input logic [3:0] sz,
                         input logic [31:0] ad, input logic [3:0] mk,
                         input logic [31:0] dt, output int t);
      int g = 0;
      tl_a_opcode  = op;
      tl_a_size    = sz;
      tl_a_address = ad;
      tl_a_mask    = mk;
      tl_a_data    = dt;
      tl_a_valid   = 1'b1;
      while (!tl_a_ready && g < 50) begin
         tick();
         g++;
      end
      if (!tl_a_ready) begin
         checks++;
         errors++;
         $display("FAIL a_ready timeout: got 0 want 1");
      end
      t = cyc;
      tick();
      tl_a_valid = 1'b0;
   endtask

   task automatic collect(input string tag, input int n_exp,
                          input logic [2:0] op, input logic den,
                          input logic cor, input logic [3:0] sz,
                          input bit use_data, input int word,
                          input int t0, input int lat,
                          input int stall_at, input int stall_len);
      int got = 0;
      int guard = 0;
      int stalled = 0;
      int first_c = -1;
      int last_c = -1;
      logic [31:0] held = 32'd0;
      logic [31:0] exp_d;
      while (got < n_exp && guard < 300) begin
         if (got == stall_at && stalled < stall_len && tl_d_valid) begin
            tl_d_ready = 1'b0;
            if (stalled == 0) held = tl_d_data;
            else check($sformatf("%s stall hold", tag), tl_d_data, held);
            stalled++;
         end else begin
            tl_d_ready = 1'b1;
         end
         if (tl_d_valid && tl_d_ready) begin
            if (got == 0) first_c = cyc;
            last_c = cyc;
            exp_d = use_data ? model[word + got] : 32'd0;
            check($sformatf("%s beat%0d data", tag, got),
                  tl_d_data, exp_d);
            check($sformatf("%s beat%0d hdr", tag, got),
                  {20'd0, tl_d_param, tl_d_opcode, tl_d_denied,
                   tl_d_corrupt, tl_d_size},
                  {20'd0, 2'b00, op, den, cor, sz});
            got++;
         end
         tick();
         guard++;
      end
      tl_d_ready = 1'b1;
      check($sformatf("%s beats", tag), got, n_exp);
      check($sformatf("%s first lat", tag), first_c - t0, lat);
      check($sformatf("%s span", tag), last_c - first_c,
            n_exp - 1 + stall_len);
      check($sformatf("%s idle ready", tag), {31'd0, tl_a_ready}, 1);
      check($sformatf("%s idle valid", tag), {31'd0, tl_d_valid}, 0);
   endtask

   initial begin
      int t;
      int got;
      int guard;
      logic [31:0] exp_put;

      for (int i = 0; i < 4096; i++) begin
         model[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0003;
      end
      model[4] = 32'h1122_3344;
      for (int i = 0; i < 4096; i++) begin
         dut.u_ram.mem[i] = model[i];
      end

      //        op            sz    addr      nA nD d_op        den  cor  dat wrd    lat
      vec[0]  = '{TL_GET,     4'd7, 32'h0080, 1, 32, TL_ACKDATA, 1'b0, 1'b0, 1, 'h20,  2};
      vec[1]  = '{TL_GET,     4'd7, 32'h0084, 1, 32, TL_ACKDATA, 1'b1, 1'b1, 0, 0,     2};
      vec[2]  = '{TL_GET,     4'd2, 32'h0040, 1, 1,  TL_ACKDATA, 1'b0, 1'b0, 1, 'h10,  2};
      vec[3]  = '{TL_GET,     4'd2, 32'h3FFC, 1, 1,  TL_ACKDATA, 1'b0, 1'b0, 1, 'hFFF, 2};
      vec[4]  = '{TL_GET,     4'd2, 32'h4000, 1, 1,  TL_ACKDATA, 1'b1, 1'b1, 0, 0,     2};
      vec[5]  = '{TL_GET,     4'd7, 32'h3F80, 1, 32, TL_ACKDATA, 1'b0, 1'b0, 1, 'hFE0, 2};
      vec[6]  = '{TL_GET,     4'd8, 32'h0000, 1, 1,  TL_ACKDATA, 1'b1, 1'b1, 0, 0,     2};
      vec[7]  = '{3'd2,       4'd2, 32'h0000, 1, 1,  TL_ACK,     1'b1, 1'b0, 0, 0,     1};
      vec[8]  = '{TL_PUTFULL, 4'd4, 32'h0020, 4, 1,  TL_ACK,     1'b1, 1'b0, 0, 0,     1};
      vec[9]  = '{TL_GET,     4'd4, 32'h0020, 1, 4,  TL_ACKDATA, 1'b0, 1'b0, 1, 8,     2};
      vec[10] = '{TL_GET,     4'd3, 32'h0100, 1, 2,  TL_ACKDATA, 1'b0, 1'b0, 1, 'h40,  2};
      vec[11] = '{TL_GET,     4'd0, 32'h0007, 1, 1,  TL_ACKDATA, 1'b0, 1'b0, 1, 1,     2};
      vec[12] = '{TL_GET,     4'd1, 32'h0003, 1, 1,  TL_ACKDATA, 1'b1, 1'b1, 0, 0,     2};
      vec[13] = '{TL_PUTFULL, 4'd3, 32'h0008, 2, 1,  TL_ACK,     1'b1, 1'b0, 0, 0,     1};

      repeat (3) tick();
      check("rst a_ready", {31'd0, tl_a_ready}, 0);
      check("rst d_valid", {31'd0, tl_d_valid}, 0);
      check("rst d_hdr", {23'd0, tl_d_param, tl_d_opcode, tl_d_denied,
                          tl_d_corrupt, tl_d_size}, 0);
      check("rst d_data", tl_d_data, 0);
      core_reset_ni = 1'b1;
      #1;
      check("post rst a_ready", {31'd0, tl_a_ready}, 1);

      for (int v = 0; v < NV; v++) begin
         for (int b = 0; b < vec[v].n_a; b++) begin
            a_send(vec[v].op, vec[v].sz, vec[v].addr, 4'hF,
                   32'hDEAD_BEEF, t);
         end
         collect($sformatf("vec%0d", v), vec[v].n_d, vec[v].d_op,
                 vec[v].den, vec[v].cor, vec[v].sz, vec[v].use_data,
                 vec[v].word, t, vec[v].lat, -1, 0);
      end

      a_send(TL_GET, 4'd7, 32'h0080, 4'hF, 32'd0, t);
      collect("stall", 32, TL_ACKDATA, 1'b0, 1'b0, 4'd7, 1, 'h20,
              t, 2, 5, 3);

      exp_put = PUT ? 32'h11BB_33DD : 32'h1122_3344;
      a_send(TL_PUTPARTIAL, 4'd2, 32'h0010, 4'b0101, 32'hAABB_CCDD, t);
      collect("put", 1, TL_ACK, !PUT, 1'b0, 4'd2, 0, 0, t, 1, -1, 0);
      model[4] = exp_put;
      a_send(TL_GET, 4'd2, 32'h0010, 4'hF, 32'd0, t);
      collect("put rd", 1, TL_ACKDATA, 1'b0, 1'b0, 4'd2, 1, 4,
              t, 2, -1, 0);
      check("put merged", model[4], exp_put);

      a_send(TL_GET, 4'd7, 32'h0080, 4'hF, 32'd0, t);
      got = 0;
      guard = 0;
      while (got < 10 && guard < 100) begin
         if (tl_d_valid) begin
            check($sformatf("rstb beat%0d", got), tl_d_data,
                  model['h20 + got]);
            got++;
         end
         tick();
         guard++;
      end
      check("rstb beat10 valid", {31'd0, tl_d_valid}, 1);
      core_reset_ni = 1'b0;
      tick();
      check("rstb d_valid", {31'd0, tl_d_valid}, 0);
      check("rstb a_ready", {31'd0, tl_a_ready}, 0);
      core_reset_ni = 1'b1;
      tick();
      check("rstb after valid", {31'd0, tl_d_valid}, 0);
      check("rstb after data", tl_d_data, 0);
      a_send(TL_GET, 4'd3, 32'h0200, 4'hF, 32'd0, t);
      collect("rst regain", 2, TL_ACKDATA, 1'b0, 1'b0, 4'd3, 1, 'h80,
              t, 2, -1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
